// File: rtl/rf_seq_ctrl.sv
// Micro-sequencer for the in-array compute register file: walks one decoded
// instruction through EXEC / MEM / WB / BR_EVAL and runs the data-memory handshake.
module rf_seq_ctrl #(
   parameter int XLEN        = 32,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      op_class,
   input  logic [1:0]      alu_fn,
   input  logic            sub,
   input  logic [1:0]      br_fn,
   input  logic [4:0]      rs1_idx,
   input  logic [4:0]      rs2_idx,
   input  logic [4:0]      rd_idx,
   input  logic            mem_ack,
   input  logic            buffer_carry_out,
   input  logic [XLEN-1:0] buf_data,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic            br_taken,
   output logic            mem_req,
   output logic            mem_we,
   output logic [4:0]      rs1_index,
   output logic [4:0]      rs2_index,
   output logic [4:0]      rd_index,
   output logic            write_en,
   output logic            op_enable,
   output logic            data2bus_en,
   output logic            exp_go_up,
   output logic            buffer_read,
   output logic            buffer_write,
   output logic            inv_en,
   output logic            carry_in,
   output logic            imm_en,
   output logic            imm_up_en,
   output logic            pc_plus_en,
   output logic            pc_imm_en,
   output logic            dataFM_en,
   output logic [3:0]      op_fa,
   output logic [2:0]      state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_EXEC    = 3'd1,
      S_MEM     = 3'd2,
      S_WB      = 3'd3,
      S_BR_EVAL = 3'd4,
      S_DONE    = 3'd5
   } state_e;

   localparam logic [2:0] OP_ALU_RR = 3'd0;
   localparam logic [2:0] OP_ALU_RI = 3'd1;
   localparam logic [2:0] OP_LOAD   = 3'd2;
   localparam logic [2:0] OP_STORE  = 3'd3;
   localparam logic [2:0] OP_BRANCH = 3'd4;
   localparam logic [2:0] OP_JAL    = 3'd5;
   localparam logic [2:0] OP_LUI    = 3'd6;
   localparam logic [2:0] OP_AUIPC  = 3'd7;
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

   state_e           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [1:0]       fn_q, fn_d;
   logic             sub_q, sub_d;
   logic [1:0]       br_fn_q, br_fn_d;
   logic [4:0]       rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             br_taken_q, br_taken_d;
   logic [CNT_W-1:0] cnt_inc;
   logic             eq, ltu;

   assign cnt_inc = cnt_q + CNT_W'(1);
   assign eq      = (buf_data == '0);
   // buffer row holds rs1 + ~rs2 + 1; no carry out means rs1 < rs2 unsigned
   assign ltu     = ~buffer_carry_out;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         op_q       <= '0;
         fn_q       <= '0;
         sub_q      <= 1'b0;
         br_fn_q    <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rd_q       <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         br_taken_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         fn_q       <= fn_d;
         sub_q      <= sub_d;
         br_fn_q    <= br_fn_d;
         rs1_q      <= rs1_d;
         rs2_q      <= rs2_d;
         rd_q       <= rd_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         br_taken_q <= br_taken_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      fn_d       = fn_q;
      sub_d      = sub_q;
      br_fn_d    = br_fn_q;
      rs1_d      = rs1_q;
      rs2_d      = rs2_q;
      rd_d       = rd_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      br_taken_d = br_taken_q;
      case (state_q)
         S_IDLE: begin
            err_d      = 1'b0;
            br_taken_d = 1'b0;
            cnt_d      = '0;
            if (start) begin
               op_d    = op_class;
               fn_d    = alu_fn;
               sub_d   = sub;
               br_fn_d = br_fn;
               rs1_d   = rs1_idx;
               rs2_d   = rs2_idx;
               rd_d    = rd_idx;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (op_q == OP_LOAD || op_q == OP_STORE) state_d = S_MEM;
            else if (op_q == OP_BRANCH)              state_d = S_BR_EVAL;
            else                                     state_d = S_DONE;
         end
         S_MEM: begin
            if (mem_ack) begin
               state_d = (op_q == OP_LOAD) ? S_WB : S_DONE;
            end else begin
               cnt_d = cnt_inc;
               if (MEM_TIMEOUT != 0 && cnt_inc == TIMEOUT_C) begin
                  state_d = S_DONE;
                  err_d   = 1'b1;
               end
            end
         end
         S_WB: state_d = S_DONE;
         S_BR_EVAL: begin
            case (br_fn_q)
               2'd0:    br_taken_d = eq;
               2'd1:    br_taken_d = ~eq;
               2'd2:    br_taken_d = ltu;
               default: br_taken_d = ~ltu;
            endcase
            state_d = S_DONE;
         end
         S_DONE: begin
            cnt_d      = '0;
            err_d      = 1'b0;
            br_taken_d = 1'b0;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   logic ex, ls_phase, wr_req;

   always_comb begin
      ex           = (state_q == S_EXEC);
      ls_phase     = ex || (state_q == S_MEM);
      wr_req       = 1'b0;
      op_enable    = 1'b0;
      data2bus_en  = 1'b0;
      exp_go_up    = 1'b0;
      buffer_read  = 1'b0;
      buffer_write = 1'b0;
      inv_en       = 1'b0;
      carry_in     = 1'b0;
      imm_en       = 1'b0;
      imm_up_en    = 1'b0;
      pc_plus_en   = 1'b0;
      pc_imm_en    = 1'b0;
      dataFM_en    = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      op_fa        = 4'b0000;
      case (op_q)
         OP_ALU_RR, OP_ALU_RI: if (ex) begin
            op_enable   = 1'b1;
            data2bus_en = (op_q == OP_ALU_RR);
            imm_en      = (op_q == OP_ALU_RI);
            wr_req      = 1'b1;
            inv_en      = sub_q & (fn_q == 2'd0);
            carry_in    = sub_q & (fn_q == 2'd0);
            op_fa       = 4'b0001 << fn_q;
         end
         // address add stays on the bus for the whole memory phase
         OP_LOAD, OP_STORE: if (ls_phase) begin
            op_enable   = 1'b1;
            exp_go_up   = 1'b1;
            imm_en      = 1'b1;
            data2bus_en = (op_q == OP_STORE);
            op_fa       = 4'b0001;
         end
         OP_BRANCH: if (ex) begin
            op_enable    = 1'b1;
            data2bus_en  = 1'b1;
            inv_en       = 1'b1;
            carry_in     = 1'b1;
            buffer_write = 1'b1;
            op_fa        = 4'b0001;
         end
         OP_JAL:   if (ex) begin pc_plus_en = 1'b1; wr_req = 1'b1; end
         OP_LUI:   if (ex) begin imm_up_en  = 1'b1; wr_req = 1'b1; end
         OP_AUIPC: if (ex) begin pc_imm_en  = 1'b1; wr_req = 1'b1; end
         default: ;
      endcase
      if (state_q == S_MEM) begin
         mem_req = 1'b1;
         mem_we  = (op_q == OP_STORE);
      end
      if (state_q == S_WB) begin
         dataFM_en = 1'b1;
         wr_req    = 1'b1;
      end
      if (state_q == S_BR_EVAL) buffer_read = 1'b1;
      write_en = wr_req && (rd_q != 5'd0);
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign err       = err_q;
   assign br_taken  = br_taken_q;
   assign rs1_index = rs1_q;
   assign rs2_index = rs2_q;
   assign rd_index  = rd_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_rf_seq_ctrl.sv
// Directed table-driven bench for rf_seq_ctrl: per-instruction EXEC decode,
// latency, memory/write counts, branch outcome, plus reset-abort sequence.
module tb_rf_seq_ctrl;
   localparam int XLEN = 32;

   localparam logic [18:0] C_WE  = 19'h40000;
   localparam logic [18:0] C_OPE = 19'h20000;
   localparam logic [18:0] C_D2B = 19'h10000;
   localparam logic [18:0] C_EGU = 19'h08000;
   localparam logic [18:0] C_BRD = 19'h04000;
   localparam logic [18:0] C_BWR = 19'h02000;
   localparam logic [18:0] C_INV = 19'h01000;
   localparam logic [18:0] C_CIN = 19'h00800;
   localparam logic [18:0] C_IMM = 19'h00400;
   localparam logic [18:0] C_IUP = 19'h00200;
   localparam logic [18:0] C_PCP = 19'h00100;
   localparam logic [18:0] C_PCI = 19'h00080;
   localparam logic [18:0] C_DFM = 19'h00040;
   localparam logic [18:0] C_MRQ = 19'h00020;
   localparam logic [18:0] C_MWE = 19'h00010;
   localparam logic [18:0] FA_SUM = 19'h1, FA_AND = 19'h2, FA_XOR = 19'h4, FA_OR = 19'h8;
   localparam int NEVER = 1000;

   logic clk = 1'b0, rst = 1'b0, start = 1'b0;
   logic [2:0] op_class = '0;
   logic [1:0] alu_fn = '0, br_fn = '0;
   logic sub = 1'b0, mem_ack = 1'b0, buffer_carry_out = 1'b0;
   logic [4:0] rs1_idx = '0, rs2_idx = '0, rd_idx = '0;
   logic [XLEN-1:0] buf_data = '0;
   logic busy, done, err, br_taken, mem_req, mem_we;
   logic [4:0] rs1_index, rs2_index, rd_index;
   logic write_en, op_enable, data2bus_en, exp_go_up, buffer_read, buffer_write;
   logic inv_en, carry_in, imm_en, imm_up_en, pc_plus_en, pc_imm_en, dataFM_en;
   logic [3:0] op_fa;
   logic [2:0] state_dbg;

   int checks = 0;
   int failures = 0;

   rf_seq_ctrl #(.XLEN(XLEN), .MEM_TIMEOUT(16), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .start(start), .op_class(op_class), .alu_fn(alu_fn),
      .sub(sub), .br_fn(br_fn), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rd_idx(rd_idx),
      .mem_ack(mem_ack), .buffer_carry_out(buffer_carry_out), .buf_data(buf_data),
      .busy(busy), .done(done), .err(err), .br_taken(br_taken), .mem_req(mem_req),
      .mem_we(mem_we), .rs1_index(rs1_index), .rs2_index(rs2_index), .rd_index(rd_index),
      .write_en(write_en), .op_enable(op_enable), .data2bus_en(data2bus_en),
      .exp_go_up(exp_go_up), .buffer_read(buffer_read), .buffer_write(buffer_write),
      .inv_en(inv_en), .carry_in(carry_in), .imm_en(imm_en), .imm_up_en(imm_up_en),
      .pc_plus_en(pc_plus_en), .pc_imm_en(pc_imm_en), .dataFM_en(dataFM_en),
      .op_fa(op_fa), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench time limit");
   end

   typedef struct {
      logic [2:0]      op;
      logic [1:0]      fn;
      logic            sb;
      logic [1:0]      br;
      logic [4:0]      rs1, rs2, rd;
      int              ack_k;
      logic [XLEN-1:0] bufd;
      logic            carry;
      logic [18:0]     exp_ctrl;
      int              exp_lat;
      logic            exp_err;
      logic            exp_br;
      int              exp_memc;
      int              exp_wr;
      int              exp_dfm;
   } vec_t;

   vec_t vecs[18];

   function automatic vec_t mk(input logic [2:0] op, input logic [1:0] fn, input logic sb,
                               input logic [1:0] br, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input int ack_k, input logic [XLEN-1:0] bufd,
                               input logic carry, input logic [18:0] exp_ctrl, input int exp_lat,
                               input logic exp_err, input logic exp_br, input int exp_memc,
                               input int exp_wr, input int exp_dfm);
      vec_t v;
      v.op = op; v.fn = fn; v.sb = sb; v.br = br;
      v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.ack_k = ack_k;
      v.bufd = bufd; v.carry = carry; v.exp_ctrl = exp_ctrl; v.exp_lat = exp_lat;
      v.exp_err = exp_err; v.exp_br = exp_br; v.exp_memc = exp_memc;
      v.exp_wr = exp_wr; v.exp_dfm = exp_dfm;
      return v;
   endfunction

   function automatic logic [18:0] ctrl_vec();
      return {write_en, op_enable, data2bus_en, exp_go_up, buffer_read, buffer_write,
              inv_en, carry_in, imm_en, imm_up_en, pc_plus_en, pc_imm_en, dataFM_en,
              mem_req, mem_we, op_fa};
   endfunction

   function automatic logic [63:0] all_outs();
      return 64'({busy, done, err, br_taken, rs1_index, rs2_index, rd_index,
                  ctrl_vec(), state_dbg});
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Entered at a negedge while the DUT is idle; returns at the negedge of the
   // IDLE cycle that follows DONE, so consecutive calls issue back-to-back.
   task automatic run_vec(input int idx, input vec_t v);
      int lat = 0, memc = 0, wr = 0, dfm = 0, mwe = 0, bw_c = 0, brd_c = 0;
      check($sformatf("v%0d idle_busy", idx), 64'(busy), 64'd0);
      start = 1'b1; op_class = v.op; alu_fn = v.fn; sub = v.sb; br_fn = v.br;
      rs1_idx = v.rs1; rs2_idx = v.rs2; rd_idx = v.rd;
      buf_data = v.bufd; buffer_carry_out = v.carry;
      @(posedge clk);
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == 1) begin
            check($sformatf("v%0d exec_ctrl", idx), 64'(ctrl_vec()), 64'(v.exp_ctrl));
            check($sformatf("v%0d idx", idx), 64'({rs1_index, rs2_index, rd_index}),
                  64'({v.rs1, v.rs2, v.rd}));
         end
         memc += int'(mem_req);
         wr   += int'(write_en);
         dfm  += int'(dataFM_en);
         mwe  += int'(mem_we);
         if (buffer_write && bw_c == 0) bw_c = c;
         if (buffer_read && brd_c == 0) brd_c = c;
         mem_ack = (c == 2 + v.ack_k);
         if (done) begin
            lat = c;
            check($sformatf("v%0d err", idx), 64'(err), 64'(v.exp_err));
            check($sformatf("v%0d br_taken", idx), 64'(br_taken), 64'(v.exp_br));
            break;
         end
      end
      mem_ack = 1'b0;
      check($sformatf("v%0d latency", idx), 64'(lat), 64'(v.exp_lat));
      check($sformatf("v%0d mem_req_cycles", idx), 64'(memc), 64'(v.exp_memc));
      check($sformatf("v%0d mem_we_cycles", idx), 64'(mwe),
            64'((v.op == 3'd3) ? v.exp_memc : 0));
      check($sformatf("v%0d write_cycles", idx), 64'(wr), 64'(v.exp_wr));
      check($sformatf("v%0d dataFM_cycles", idx), 64'(dfm), 64'(v.exp_dfm));
      if (v.op == 3'd4)
         check($sformatf("v%0d bw_then_br", idx), 64'({bw_c, brd_c}), 64'({32'd1, 32'd2}));
      @(negedge clk);
      check($sformatf("v%0d back_to_idle", idx), 64'({busy, done, err, br_taken}), 64'd0);
   endtask

   initial begin
      vecs[0]  = mk(3'd0, 2'd0, 1'b1, 2'd0, 5'd3,  5'd4,  5'd5,  0, '0, 1'b0,
                    C_WE|C_OPE|C_D2B|C_INV|C_CIN|FA_SUM, 2, 1'b0, 1'b0, 0, 1, 0);
      vecs[1]  = mk(3'd1, 2'd2, 1'b0, 2'd0, 5'd7,  5'd8,  5'd0,  0, '0, 1'b0,
                    C_OPE|C_IMM|FA_XOR, 2, 1'b0, 1'b0, 0, 0, 0);
      vecs[2]  = mk(3'd0, 2'd1, 1'b1, 2'd0, 5'd1,  5'd2,  5'd7,  0, '0, 1'b0,
                    C_WE|C_OPE|C_D2B|FA_AND, 2, 1'b0, 1'b0, 0, 1, 0);
      vecs[3]  = mk(3'd1, 2'd3, 1'b0, 2'd0, 5'd11, 5'd12, 5'd9,  0, '0, 1'b0,
                    C_WE|C_OPE|C_IMM|FA_OR, 2, 1'b0, 1'b0, 0, 1, 0);
      vecs[4]  = mk(3'd2, 2'd0, 1'b0, 2'd0, 5'd13, 5'd14, 5'd6,  3, '0, 1'b0,
                    C_OPE|C_EGU|C_IMM|FA_SUM, 7, 1'b0, 1'b0, 4, 1, 1);
      vecs[5]  = mk(3'd3, 2'd0, 1'b0, 2'd0, 5'd15, 5'd16, 5'd17, 0, '0, 1'b0,
                    C_OPE|C_EGU|C_IMM|C_D2B|FA_SUM, 3, 1'b0, 1'b0, 1, 0, 0);
      vecs[6]  = mk(3'd4, 2'd0, 1'b0, 2'd0, 5'd18, 5'd19, 5'd20, 0, 32'd0, 1'b1,
                    C_OPE|C_D2B|C_INV|C_CIN|C_BWR|FA_SUM, 3, 1'b0, 1'b1, 0, 0, 0);
      vecs[7]  = mk(3'd4, 2'd0, 1'b0, 2'd0, 5'd21, 5'd22, 5'd0,  0, 32'd5, 1'b1,
                    C_OPE|C_D2B|C_INV|C_CIN|C_BWR|FA_SUM, 3, 1'b0, 1'b0, 0, 0, 0);
      vecs[8]  = mk(3'd4, 2'd0, 1'b0, 2'd1, 5'd23, 5'd24, 5'd0,  0, 32'd5, 1'b1,
                    C_OPE|C_D2B|C_INV|C_CIN|C_BWR|FA_SUM, 3, 1'b0, 1'b1, 0, 0, 0);
      vecs[9]  = mk(3'd4, 2'd0, 1'b0, 2'd2, 5'd25, 5'd26, 5'd0,  0, 32'hFFFF_FFFE, 1'b0,
                    C_OPE|C_D2B|C_INV|C_CIN|C_BWR|FA_SUM, 3, 1'b0, 1'b1, 0, 0, 0);
      vecs[10] = mk(3'd4, 2'd0, 1'b0, 2'd3, 5'd27, 5'd28, 5'd0,  0, 32'hFFFF_FFFE, 1'b0,
                    C_OPE|C_D2B|C_INV|C_CIN|C_BWR|FA_SUM, 3, 1'b0, 1'b0, 0, 0, 0);
      vecs[11] = mk(3'd4, 2'd0, 1'b0, 2'd3, 5'd29, 5'd30, 5'd0,  0, 32'd2, 1'b1,
                    C_OPE|C_D2B|C_INV|C_CIN|C_BWR|FA_SUM, 3, 1'b0, 1'b1, 0, 0, 0);
      vecs[12] = mk(3'd5, 2'd0, 1'b0, 2'd0, 5'd0,  5'd0,  5'd1,  0, '0, 1'b0,
                    C_WE|C_PCP, 2, 1'b0, 1'b0, 0, 1, 0);
      vecs[13] = mk(3'd6, 2'd0, 1'b0, 2'd0, 5'd0,  5'd0,  5'd2,  0, '0, 1'b0,
                    C_WE|C_IUP, 2, 1'b0, 1'b0, 0, 1, 0);
      vecs[14] = mk(3'd7, 2'd0, 1'b0, 2'd0, 5'd0,  5'd0,  5'd0,  0, '0, 1'b0,
                    C_PCI, 2, 1'b0, 1'b0, 0, 0, 0);
      vecs[15] = mk(3'd2, 2'd0, 1'b0, 2'd0, 5'd4,  5'd5,  5'd8,  NEVER, '0, 1'b0,
                    C_OPE|C_EGU|C_IMM|FA_SUM, 18, 1'b1, 1'b0, 16, 0, 0);
      vecs[16] = mk(3'd2, 2'd0, 1'b0, 2'd0, 5'd6,  5'd7,  5'd10, 0, '0, 1'b0,
                    C_OPE|C_EGU|C_IMM|FA_SUM, 4, 1'b0, 1'b0, 1, 1, 1);
      vecs[17] = mk(3'd3, 2'd0, 1'b0, 2'd0, 5'd8,  5'd9,  5'd11, 2, '0, 1'b0,
                    C_OPE|C_EGU|C_IMM|C_D2B|FA_SUM, 5, 1'b0, 1'b0, 3, 0, 0);

      repeat (3) @(negedge clk);
      check("reset_outputs", all_outs(), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      check("post_reset_idle", all_outs(), 64'd0);

      for (int i = 0; i < 18; i++) run_vec(i, vecs[i]);

      // Reset asserted while a LOAD is waiting in MEM must abort without done.
      start = 1'b1; op_class = 3'd2; alu_fn = 2'd0; sub = 1'b0; br_fn = 2'd0;
      rs1_idx = 5'd3; rs2_idx = 5'd4; rd_idx = 5'd12;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("abort_in_mem", 64'({mem_req, busy}), 64'b11);
      #2 rst = 1'b0;
      #1 check("abort_outputs_zero", all_outs(), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      begin
         int done_seen = 0, busy_seen = 0;
         for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            done_seen += int'(done);
            busy_seen += int'(busy);
         end
         check("abort_no_done", 64'(done_seen), 64'd0);
         check("abort_not_busy", 64'(busy_seen), 64'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/rf_seq_ctrl.md
Name: rf_seq_ctrl

Overview:
Multi-cycle micro-sequencer that drives the control inputs of the in-array compute register file (33-row cell array; row 32 is the scratch buffer) for one instruction at a time.
It accepts a decoded instruction on a start/busy/done handshake and steps the register file through compute, memory, write-back and branch-compare phases.
It also runs the data-memory request handshake, including a timeout.

Parameters:
XLEN, 32, datapath width; must equal register-file COLS.
MEM_TIMEOUT, 16, maximum cycles mem_req waits for mem_ack; 0 disables the timeout.
CNT_W, 5, timeout counter width; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  instruction valid; sampled only in IDLE
op_class  in  3  0 ALU_RR, 1 ALU_RI, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 LUI, 7 AUIPC
alu_fn  in  2  0 add, 1 and, 2 xor, 3 or
sub  in  1  with alu_fn=0: subtract
br_fn  in  2  0 BEQ, 1 BNE, 2 BLTU, 3 BGEU
rs1_idx/rs2_idx/rd_idx  in  5 each  register indices
mem_ack  in  1  memory completion
buffer_carry_out  in  1  register-file buffer-row carry out
buf_data  in  XLEN  register-file data2Mem (buffer-row read value)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
err  out  1  valid with done; memory timeout
br_taken  out  1  valid with done for BRANCH, else 0
mem_req/mem_we  out  1 each  memory request / write qualifier
rs1_index/rs2_index/rd_index  out  5 each  latched indices to the register file
write_en, op_enable, data2bus_en, exp_go_up, buffer_read, buffer_write, inv_en, carry_in, imm_en, imm_up_en, pc_plus_en, pc_imm_en, dataFM_en  out  1 each  register-file controls
op_fa  out  4  one-hot: bit0 sum, bit1 and, bit2 xor, bit3 or

Behaviour:
- While rst=0, all outputs are 0, the state is IDLE and the counter is 0.
- Asserting rst mid-instruction aborts it immediately; no done pulse is produced.
- State and the latched fields (class, fn, sub, indices) are registered.
- Register-file controls are a combinational decode of (state, latched fields) and are glitch-free relative to clk.
- States: IDLE, EXEC, MEM, WB, BR_EVAL, DONE.
- IDLE: when start=1, latch all fields and go to EXEC. start is ignored in every other state.
- op_fa is one-hot from alu_fn in EXEC for ALU_RR/ALU_RI, forced to sum for LOAD/STORE/BRANCH, and 0 elsewhere.
- write_en is never asserted when rd_idx=0.
- EXEC for ALU_RR: op_enable, data2bus_en and write_en; inv_en=carry_in=sub&(alu_fn==0). Next state DONE.
- EXEC for ALU_RI: as ALU_RR but imm_en instead of data2bus_en. Next state DONE.
- EXEC for LOAD: op_enable, exp_go_up, imm_en, sum. Next state MEM.
- EXEC for STORE: as LOAD plus data2bus_en. Next state MEM.
- MEM: holds all EXEC controls and asserts mem_req; mem_we=1 for STORE.
  - mem_ack=1 in any MEM cycle (including the first) → LOAD goes to WB, STORE goes to DONE.
  - The counter increments each MEM cycle without ack. If it reaches MEM_TIMEOUT → DONE with err=1 and no write-back.
- WB (LOAD only): dataFM_en and write_en. Next state DONE.
- EXEC for BRANCH: op_enable, data2bus_en, sum, inv_en=1, carry_in=1, buffer_write=1, so rs1−rs2 lands in the buffer row. Next state BR_EVAL.
- BR_EVAL: buffer_read=1; eq=(buf_data==0), ltu=~buffer_carry_out.
  - Register br_taken: BEQ→eq, BNE→~eq, BLTU→ltu, BGEU→~ltu.
  - Next state DONE. No architectural register is written.
- EXEC for JAL/LUI/AUIPC: pc_plus_en / imm_up_en / pc_imm_en respectively, with write_en. Next state DONE.
- DONE: done=1 for one cycle; err and br_taken are valid; counter cleared. Next state IDLE. err and br_taken clear on return to IDLE.
- Latency from start-accept edge to done:
  - ALU/JAL/LUI/AUIPC: 2 cycles.
  - BRANCH: 3 cycles.
  - STORE: 3+k cycles; LOAD: 4+k cycles, where k is the number of MEM wait cycles.
- Back-to-back issue: start may be accepted in the IDLE cycle after DONE.

Test Plan:
- Reset: assert rst=0 mid-LOAD in MEM → all outputs 0 immediately; after release busy=0 and no done pulse.
- ALU_RR sub (rs1=3, rs2=4, rd=5, alu_fn=0, sub=1) → EXEC shows op_enable=data2bus_en=write_en=inv_en=carry_in=1, op_fa=0001; done 2 cycles after accept.
- ALU_RI with rd=0, alu_fn=2 → op_fa=0100, imm_en=1, write_en stays 0; done after 2 cycles.
- LOAD with mem_ack after 3 wait cycles → mem_req high for 4 cycles, then WB with dataFM_en=write_en=1; done 7 cycles after accept, err=0. Repeat with STORE, ack in the first MEM cycle → mem_we=1, done 3 cycles after accept.
- LOAD with mem_ack never asserted, MEM_TIMEOUT=16 → mem_req high for 16 cycles, done with err=1, write_en never asserted.
- BRANCH: BEQ with buf_data=0 → br_taken=1; BLTU with buffer_carry_out=0 → 1; BGEU with buffer_carry_out=0 → 0. Each has done 3 cycles after accept and buffer_write one cycle before buffer_read.
